// File: rtl/pll_reconfig_seq.sv
// Memory-clock PLL reconfiguration sequencer.
// Writes the fixed M/K/C0 register table, pulses PLL reset, waits for stable lock.
module pll_reconfig_seq #(
  parameter int unsigned GAP          = 7,
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned LOCK_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] m_val,
  input  logic [31:0] k_val,
  input  logic [31:0] c0_val,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        pll_reset
);

  typedef enum logic [2:0] {IDLE, WR, GAPW, PRST, LOCK} state_t;

  state_t      state;
  logic [31:0] m_q, k_q, c0_q;
  logic [2:0]  idx;
  logic [7:0]  gcnt;
  logic [7:0]  rcnt;
  logic [15:0] stab, stab_n;
  logic [31:0] tmo, tmo_n;
  logic        pend;

  function automatic logic [37:0] wr_entry(
    input logic [2:0]  i,
    input logic [31:0] m,
    input logic [31:0] k,
    input logic [31:0] c0
  );
    logic [37:0] e;
    unique case (i)
      3'd0: e = {6'd0, 32'd0};
      3'd1: e = {6'd4, m};
      3'd2: e = {6'd7, k};
      3'd3: e = {6'd3, 32'h10000};
      3'd4: e = {6'd5, c0};
      3'd5: e = {6'd9, 32'd1};
      3'd6: e = {6'd8, 32'd7};
      3'd7: e = {6'd2, 32'd0};
    endcase
    return e;
  endfunction

  // saturating lock counters
  always_comb begin
    stab_n = '0;
    if (pll_locked)
      stab_n = (stab == '1) ? stab : stab + 16'd1;
    tmo_n = (tmo == '1) ? tmo : tmo + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      mgmt_write     <= 1'b0;
      pll_reset      <= 1'b0;
      m_q            <= '0;
      k_q            <= '0;
      c0_q           <= '0;
      idx            <= '0;
      gcnt           <= '0;
      rcnt           <= '0;
      stab           <= '0;
      tmo            <= '0;
      pend           <= 1'b0;
    end else begin
      if (req && busy)
        pend <= 1'b1;
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req || pend) begin
            m_q        <= m_val;
            k_q        <= k_val;
            c0_q       <= c0_val;
            idx        <= '0;
            pend       <= 1'b0;
            busy       <= 1'b1;
            mgmt_write <= 1'b1;
            {mgmt_address, mgmt_writedata} <=
              wr_entry(3'd0, m_val, k_val, c0_val);
            state      <= WR;
          end else begin
            busy <= 1'b0;
          end
        end
        WR: begin
          if (!mgmt_waitrequest) begin
            if (idx == 3'd7) begin
              mgmt_write     <= 1'b0;
              mgmt_address   <= '0;
              mgmt_writedata <= '0;
              pll_reset      <= 1'b1;
              rcnt           <= '0;
              state          <= PRST;
            end else if (GAP == 0) begin
              idx <= idx + 3'd1;
              {mgmt_address, mgmt_writedata} <=
                wr_entry(idx + 3'd1, m_q, k_q, c0_q);
            end else begin
              mgmt_write     <= 1'b0;
              mgmt_address   <= '0;
              mgmt_writedata <= '0;
              gcnt           <= '0;
              state          <= GAPW;
            end
          end
        end
        GAPW: begin
          if (gcnt == 8'(GAP - 1)) begin
            idx        <= idx + 3'd1;
            mgmt_write <= 1'b1;
            {mgmt_address, mgmt_writedata} <=
              wr_entry(idx + 3'd1, m_q, k_q, c0_q);
            state      <= WR;
          end else begin
            gcnt <= gcnt + 8'd1;
          end
        end
        PRST: begin
          if (rcnt == 8'(RST_CYCLES - 1)) begin
            pll_reset <= 1'b0;
            stab      <= '0;
            tmo       <= '0;
            state     <= LOCK;
          end else begin
            rcnt <= rcnt + 8'd1;
          end
        end
        LOCK: begin
          stab <= stab_n;
          tmo  <= tmo_n;
          // busy holds through the done/err cycle; IDLE decides restart
          if (stab_n == 16'(LOCK_STABLE)) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (tmo_n == 32'(LOCK_TIMEOUT)) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: schedule-level model over a fixed
// stimulus timeline, compared against the DUT every cycle.
module tb_pll_reconfig_seq;

  localparam int N     = 830;
  localparam int GAP   = 7;
  localparam int RSTC  = 8;
  localparam int STAB  = 16;
  localparam int TMO   = 100;
  localparam logic [31:0] KV = 32'hB33332DD;
  localparam logic [31:0] CV = 32'h00020302;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic        prst;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] m_val;
  logic [31:0] k_val;
  logic [31:0] c0_val;
  logic        busy;
  logic        done;
  logic        err;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write;
  logic        mgmt_waitrequest;
  logic        pll_locked;
  logic        pll_reset;

  bit          rs[N];
  bit          rq[N];
  bit          st[N];
  bit          lk[N];
  logic [31:0] mv[N];
  obs_t        ex[N];

  int ncmp = 0;
  int nbad = 0;

  int addr_tab[8] = '{0, 4, 7, 3, 5, 9, 8, 2};

  always #5 clk = ~clk;

  pll_reconfig_seq #(
    .GAP(GAP),
    .RST_CYCLES(RSTC),
    .LOCK_STABLE(STAB),
    .LOCK_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .m_val(m_val),
    .k_val(k_val),
    .c0_val(c0_val),
    .busy(busy),
    .done(done),
    .err(err),
    .mgmt_address(mgmt_address),
    .mgmt_writedata(mgmt_writedata),
    .mgmt_write(mgmt_write),
    .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked(pll_locked),
    .pll_reset(pll_reset)
  );

  function automatic logic [31:0] wdat(input int i, input logic [31:0] m);
    case (i)
      1:       return m;
      2:       return KV;
      3:       return 32'h10000;
      4:       return CV;
      5:       return 32'd1;
      6:       return 32'd7;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit live(input int c);
    if (c >= N || rs[c]) return 1'b0;
    ex[c].busy = 1'b1;
    return 1'b1;
  endfunction

  // Walk each accepted request through its write/reset/lock schedule.
  task automatic model();
    int n, c, t, cnt, lst, fin;
    bit ok, rst_again, acc;
    logic [31:0] m;
    for (int i = 0; i < N; i++) ex[i] = '0;
    n = 0;
    while (n < N) begin
      if (rs[n] || !rq[n]) begin
        n++;
        continue;
      end
      t  = n;
      ok = 1'b1;
      c  = t;
      do begin
        rst_again = 1'b0;
        m = mv[t];
        c = t + 1;
        for (int i = 0; i < 8 && ok; i++) begin
          acc = 1'b0;
          while (ok && !acc) begin
            ok = live(c);
            if (ok) begin
              ex[c].wr   = 1'b1;
              ex[c].addr = 6'(addr_tab[i]);
              ex[c].data = wdat(i, m);
              acc = !st[c];
              c++;
            end
          end
          if (i < 7)
            for (int g = 0; g < GAP && ok; g++) begin
              ok = live(c);
              if (ok) c++;
            end
        end
        for (int r = 0; r < RSTC && ok; r++) begin
          ok = live(c);
          if (ok) begin
            ex[c].prst = 1'b1;
            c++;
          end
        end
        cnt = 0;
        lst = c;
        fin = 0;
        while (ok && fin == 0) begin
          ok = live(c);
          if (ok) begin
            cnt = lk[c] ? cnt + 1 : 0;
            c++;
            if (cnt == STAB) fin = 1;
            else if (c - lst == TMO) fin = 2;
          end
        end
        if (ok) ok = live(c);
        if (ok) begin
          if (fin == 1) ex[c].done = 1'b1;
          else ex[c].err = 1'b1;
          for (int x = t + 1; x <= c; x++)
            if (rq[x]) rst_again = 1'b1;
          t = c;
        end
      end while (ok && rst_again);
      n = ok ? c + 1 : c;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cmp_cycle(input int n);
    obs_t a;
    a = {busy, done, err, mgmt_write, mgmt_address, mgmt_writedata,
         pll_reset};
    ncmp++;
    if (a !== ex[n]) begin
      nbad++;
      $display("FAIL cyc%0d outputs: got b%b d%b e%b w%b a%0d wd%h r%b want b%b d%b e%b w%b a%0d wd%h r%b",
               n, a.busy, a.done, a.err, a.wr, a.addr, a.data, a.prst,
               ex[n].busy, ex[n].done, ex[n].err, ex[n].wr, ex[n].addr,
               ex[n].data, ex[n].prst);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rs[i] = (i < 4) || (i >= 780 && i <= 782);
      rq[i] = 1'b0;
      st[i] = (i >= 163 && i <= 165);
      lk[i] = (i >= 96 && i <= 115) || (i >= 204 && i <= 225) ||
              (i >= 310 && i <= 319) || (i >= 321 && i <= 340) ||
              (i >= 610 && i <= 710);
      mv[i] = (i >= 545 && i < 720) ? 32'h00707 : 32'h00808;
    end
    rq[10]  = 1'b1;
    rq[130] = 1'b1;
    rq[240] = 1'b1;
    rq[360] = 1'b1;
    rq[540] = 1'b1;
    rq[545] = 1'b1;
    rq[560] = 1'b1;
    rq[580] = 1'b1;
    rq[720] = 1'b1;
    rq[800] = 1'b1;
    model();

    chk("s1_w0",        32'(ex[11].wr),   1);
    chk("s1_gap",       32'(ex[12].wr),   0);
    chk("s1_a1",        32'(ex[19].addr), 4);
    chk("s1_d1",        ex[19].data,      32'h808);
    chk("s1_d2",        ex[27].data,      KV);
    chk("s1_a7",        32'(ex[67].addr), 2);
    chk("s1_rst_first", 32'(ex[68].prst), 1);
    chk("s1_rst_last",  32'(ex[75].prst), 1);
    chk("s1_rst_off",   32'(ex[76].prst), 0);
    chk("s1_done",      32'(ex[112].done), 1);
    chk("s1_busy_done", 32'(ex[112].busy), 1);
    chk("s1_busy_off",  32'(ex[113].busy), 0);
    chk("s2_stall_a",   32'(ex[165].addr), 5);
    chk("s2_stall_d",   ex[165].data,      CV);
    chk("s2_acc",       32'(ex[166].wr),   1);
    chk("s2_after",     32'(ex[167].wr),   0);
    chk("s2_w5",        32'(ex[174].addr), 9);
    chk("s2_rst",       32'(ex[191].prst), 1);
    chk("s2_done",      32'(ex[220].done), 1);
    chk("s3_nodone",    32'(ex[326].done), 0);
    chk("s3_done",      32'(ex[337].done), 1);
    chk("s4_noerr",     32'(ex[525].err),  0);
    chk("s4_err",       32'(ex[526].err),  1);
    chk("s4_busy_off",  32'(ex[527].busy), 0);
    chk("s5_d1a",       ex[549].data,      32'h808);
    chk("s5_done1",     32'(ex[626].done), 1);
    chk("s5_busy",      32'(ex[627].busy), 1);
    chk("s5_w0b",       32'(ex[627].wr),   1);
    chk("s5_d1b",       ex[635].data,      32'h707);
    chk("s5_done2",     32'(ex[708].done), 1);
    chk("s5_busy_off",  32'(ex[709].busy), 0);
    chk("s6_rst_on",    32'(ex[779].prst), 1);
    chk("s6_rst_drop",  32'(ex[780].prst), 0);
    chk("s6_busy_drop", 32'(ex[780].busy), 0);
    chk("s6_idle",      32'(ex[790].busy), 0);
    chk("s6_new_w0",    32'(ex[801].wr),   1);

    reset            = 1'b1;
    req              = 1'b0;
    m_val            = 32'h00808;
    k_val            = KV;
    c0_val           = CV;
    mgmt_waitrequest = 1'b0;
    pll_locked       = 1'b0;

    for (int n = 0; n < N; n++) begin
      @(posedge clk);
      #1;
      reset            = rs[n];
      req              = rq[n];
      m_val            = mv[n];
      mgmt_waitrequest = st[n];
      pll_locked       = lk[n];
      @(negedge clk);
      cmp_cycle(n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
